fetch_stage: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the decoder and drives its instruction, PC and clock-enable inputs.
- Generates the PC and fetches from instruction memory over a req/ack handshake.
- Buffers returned instructions while the decoder stalls.
- Redirects on branch/jump or flush and discards any in-flight response that belongs to the old path.

---
 rtl/fetch_stage_pkg.sv | 6 +
 rtl/fetch_fifo.sv | 36 +++
 rtl/fetch_stage.sv | 93 +++++++++
 tb/tb_fetch_stage.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared constants and state encoding for the fetch stage.
package fetch_stage_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int PC_INCR = 4;
    typedef enum logic [1:0] {FETCH = 2'd0, DISCARD = 2'd1, HALT = 2'd2} fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO holding {instr, pc} pairs while the decoder stalls.
module fetch_fifo import fetch_stage_pkg::*; #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     f_clk,
    input  logic                     f_rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rd, wr;
    assign dout  = mem[rd];
    assign empty = count == '0;
    assign full  = count == CW'(DEPTH);
    always_ff @(posedge f_clk) begin
        if (push) mem[wr] <= din;
        if (f_rst || clear) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (push) wr <= wr + AW'(1);
            if (pop) rd <= rd + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC generation, imem req/ack fetch, skid buffering and redirect handling for the decoder.
module fetch_stage import fetch_stage_pkg::*; #(
    parameter int                  IWIDTH     = 32,
    parameter int                  PC_WIDTH   = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
    parameter int                  FIFO_DEPTH = 2
) (
    input  logic                f_clk,
    input  logic                f_rst,
    output logic                f_o_imem_req,
    output logic [PC_WIDTH-1:0] f_o_imem_addr,
    input  logic                f_i_imem_ack,
    input  logic [IWIDTH-1:0]   f_i_imem_data,
    input  logic                f_i_stall,
    input  logic                f_i_flush,
    input  logic                f_i_change_pc,
    input  logic [PC_WIDTH-1:0] f_i_pc_target,
    output logic [IWIDTH-1:0]   f_o_instr,
    output logic [PC_WIDTH-1:0] f_o_pc,
    output logic                f_o_ce,
    output logic                f_o_exception
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int DW = IWIDTH + PC_WIDTH;
    fetch_state_t st;
    logic run, ack, redir, mis, push, pop, full, empty, take;
    logic [PC_WIDTH-1:0] pc, tgt;
    logic [CW-1:0] cnt;
    logic [DW-1:0] head;
    // Only request when the FIFO can absorb the response even if the decoder stalls.
    assign f_o_imem_req  = run && (st == DISCARD || (st == FETCH && cnt < CW'(FIFO_DEPTH)));
    assign f_o_imem_addr = pc;
    assign ack   = f_i_imem_ack && f_o_imem_req;
    assign redir = f_i_flush || f_i_change_pc;
    assign mis   = f_i_pc_target[1:0] != 2'b00;
    assign take  = ack && st == FETCH && !redir;
    assign push  = take && !full && (f_i_stall || !empty);
    assign pop   = !redir && !f_i_stall && !empty;
    fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DW)) u_fifo (
        .f_clk(f_clk),
        .f_rst(f_rst),
        .push(push),
        .pop(pop),
        .clear(redir),
        .din({f_i_imem_data, pc}),
        .dout(head),
        .full(full),
        .empty(empty),
        .count(cnt)
    );
    always_ff @(posedge f_clk) begin
        if (f_rst) begin
            st  <= FETCH;
            run <= 1'b0;
            pc  <= RESET_PC;
            tgt <= RESET_PC;
        end else begin
            run <= 1'b1;
            if (redir) begin
                tgt <= f_i_pc_target;
                if (mis) st <= HALT;
                else if (f_o_imem_req && !ack) st <= DISCARD;
                else begin
                    st <= FETCH;
                    pc <= f_i_pc_target;
                end
            end else if (ack) begin
                st <= FETCH;
                pc <= st == DISCARD ? tgt : pc + PC_WIDTH'(PC_INCR);
            end
        end
    end
    always_ff @(posedge f_clk) begin
        if (f_rst) begin
            f_o_instr     <= IWIDTH'(NOP_INSTR);
            f_o_pc        <= '0;
            f_o_ce        <= 1'b0;
            f_o_exception <= 1'b0;
        end else if (redir) begin
            f_o_ce        <= mis;
            f_o_exception <= mis;
            if (mis) begin
                f_o_instr <= IWIDTH'(NOP_INSTR);
                f_o_pc    <= f_i_pc_target;
            end
        end else if (!f_i_stall) begin
            f_o_exception <= 1'b0;
            f_o_ce        <= !empty || take;
            if (!empty) {f_o_instr, f_o_pc} <= head;
            else if (take) {f_o_instr, f_o_pc} <= {f_i_imem_data, pc};
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized checks of fetch_stage against a stream-level reference model.
module tb_fetch_stage;
    localparam int DEPTH = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic clk = 1'b0, rst = 1'b1, stall = 1'b0, flush = 1'b0, change = 1'b0;
    logic req, ack, ce, exc;
    logic [31:0] addr, tgt = '0, instr, pc;
    int lat = 0, wcnt = 0, cyc = 0;
    int vectors = 0, miscompares = 0;
    always #5 clk = ~clk;
    fetch_stage dut (
        .f_clk(clk),
        .f_rst(rst),
        .f_o_imem_req(req),
        .f_o_imem_addr(addr),
        .f_i_imem_ack(ack),
        .f_i_imem_data(addr | 32'h13),
        .f_i_stall(stall),
        .f_i_flush(flush),
        .f_i_change_pc(change),
        .f_i_pc_target(tgt),
        .f_o_instr(instr),
        .f_o_pc(pc),
        .f_o_ce(ce),
        .f_o_exception(exc)
    );
    // Memory: acks once a request has waited 'lat' cycles; reset alongside the stage.
    assign ack = req && (wcnt >= lat);
    always @(posedge clk) begin
        wcnt <= (rst || !req || ack) ? 0 : wcnt + 1;
        cyc  <= cyc + 1;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic next_out(output logic [31:0] opc, output logic [31:0] oin, output int oc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ce && n < 20);
        opc = pc;
        oin = instr;
        oc  = cyc;
        if (!ce) begin
            vectors++;
            miscompares++;
            $error("FAIL out_timeout: observed ce=0 for %0d cycles expected an output", n);
        end
    endtask
    // Reference model: expected instruction stream tracked as fetch/deliver addresses and a backlog count.
    logic p_rst = 1'b1, p_stall, p_redir, p_req, p_ack, p_ce, p_exc;
    logic [31:0] p_tgt, p_pc, p_instr, p_addr, fexp, oexp;
    logic disc, halted;
    int pend;
    always @(negedge clk) begin
        if (p_rst) begin
            check("rst_req", 32'(req), 32'd0);
            check("rst_addr", addr, 32'd0);
            check("rst_ce", 32'(ce), 32'd0);
            check("rst_instr", instr, NOP);
            check("rst_pc", pc, 32'd0);
            check("rst_exc", 32'(exc), 32'd0);
            pend = 0; disc = 1'b0; halted = 1'b0; fexp = '0; oexp = '0;
        end else begin
            if (p_redir) begin
                pend = 0;
                disc = p_req && !p_ack;
                halted = p_tgt[1:0] != 2'b00;
                fexp = p_tgt;
                oexp = p_tgt;
                check("redir_ce", 32'(ce), 32'(halted));
                check("redir_exc", 32'(exc), 32'(halted));
                if (halted) begin
                    check("exc_pc", pc, p_tgt);
                    check("exc_instr", instr, NOP);
                end
            end else begin
                if (p_req && p_ack) begin
                    if (disc) disc = 1'b0;
                    else begin
                        pend++;
                        fexp = fexp + 32'd4;
                    end
                end
                if (p_stall) begin
                    check("hold_ce", 32'(ce), 32'(p_ce));
                    check("hold_pc", pc, p_pc);
                    check("hold_instr", instr, p_instr);
                    check("hold_exc", 32'(exc), 32'(p_exc));
                end else begin
                    check("out_ce", 32'(ce), 32'(pend > 0));
                    if (pend > 0) begin
                        check("out_pc", pc, oexp);
                        check("out_instr", instr, oexp | 32'h13);
                        check("out_exc", 32'(exc), 32'd0);
                        oexp = oexp + 32'd4;
                        pend--;
                    end
                end
            end
            check("req", 32'(req), 32'(!halted && (disc || pend < DEPTH)));
            if (req && !disc) check("addr", addr, fexp);
            if (p_req && !p_ack) check("hold_addr", addr, p_addr);
        end
        p_rst = rst; p_stall = stall; p_redir = flush || change; p_tgt = tgt;
        p_req = req; p_ack = ack; p_addr = addr;
        p_ce = ce; p_exc = exc; p_pc = pc; p_instr = instr;
    end
    initial begin
        logic [31:0] opc, oin, lpc;
        int oc, lc, n;
        tick;
        tick;
        rst = 1'b0;
        @(negedge clk);
        check("init_req", 32'(req), 32'd0);
        check("init_instr", instr, NOP);
        // Zero-latency stream, then a 5-cycle stall with pc=8 on the output.
        next_out(opc, oin, oc);
        check("z0_pc", opc, 32'h0);
        check("z0_instr", oin, 32'h13);
        next_out(opc, oin, oc);
        check("z1_pc", opc, 32'h4);
        check("z1_instr", oin, 32'h17);
        tick;
        stall = 1'b1;
        @(negedge clk);
        check("z2_pc", pc, 32'h8);
        check("z2_instr", instr, 32'h1B);
        repeat (4) tick;
        @(negedge clk);
        check("stall_pc", pc, 32'h8);
        check("stall_req", 32'(req), 32'd0);
        tick;
        stall = 1'b0;
        @(negedge clk);
        next_out(opc, oin, lc);
        check("drain0", opc, 32'hC);
        next_out(opc, oin, oc);
        check("drain1", opc, 32'h10);
        check("drain1_gap", 32'(oc - lc), 32'd1);
        next_out(opc, oin, oc);
        check("drain2", opc, 32'h14);
        // Latency 3: one output every 4 cycles with consecutive PCs.
        tick;
        lat = 3;
        repeat (3) next_out(lpc, oin, lc);
        next_out(opc, oin, oc);
        check("lat3_gap", 32'(oc - lc), 32'd4);
        check("lat3_pc", opc - lpc, 32'd4);
        // change_pc to 0x100 while a request is outstanding.
        n = 0;
        tick;
        while (!(req && !ack) && n < 10) begin tick; n++; end
        change = 1'b1;
        tgt = 32'h100;
        tick;
        change = 1'b0;
        next_out(opc, oin, oc);
        check("redir_pc", opc, 32'h100);
        check("redir_instr", oin, 32'h113);
        // Flush to 0x40 in a stalled cycle that also acks, with the FIFO partly filled.
        tick;
        lat = 0;
        tick;
        stall = 1'b1;
        tick;
        flush = 1'b1;
        tgt = 32'h40;
        tick;
        flush = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        check("flush_ce", 32'(ce), 32'd0);
        next_out(opc, oin, oc);
        check("flush_pc", opc, 32'h40);
        // Misaligned redirect, HALT, then resume at 0x200.
        tick;
        change = 1'b1;
        tgt = 32'h102;
        tick;
        change = 1'b0;
        @(negedge clk);
        check("mis_ce", 32'(ce), 32'd1);
        check("mis_exc", 32'(exc), 32'd1);
        check("mis_pc", pc, 32'h102);
        check("mis_instr", instr, NOP);
        repeat (4) begin
            tick;
            @(negedge clk);
            check("halt_req", 32'(req), 32'd0);
            check("halt_ce", 32'(ce), 32'd0);
        end
        tick;
        change = 1'b1;
        tgt = 32'h200;
        tick;
        change = 1'b0;
        next_out(opc, oin, oc);
        check("resume_pc", opc, 32'h200);
        // Reset in the middle of a latency-3 request.
        tick;
        lat = 3;
        n = 0;
        tick;
        while (!(req && !ack) && n < 10) begin tick; n++; end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        @(negedge clk);
        check("mrst_req", 32'(req), 32'd0);
        check("mrst_addr", addr, 32'd0);
        check("mrst_ce", 32'(ce), 32'd0);
        check("mrst_pc", pc, 32'd0);
        check("mrst_instr", instr, NOP);
        next_out(opc, oin, oc);
        check("mrst_first", opc, 32'h0);
        // Randomized latency, stalls and aligned redirects.
        for (int i = 0; i < 1500; i++) begin
            tick;
            lat = $urandom_range(0, 3);
            stall = $urandom_range(0, 9) < 3;
            n = $urandom_range(0, 99);
            flush = n < 2;
            change = n >= 2 && n < 4;
            tgt = 32'((i + 1) << 12) | 32'($urandom_range(0, 255) << 2);
        end
        tick;
        flush = 1'b0;
        change = 1'b0;
        stall = 1'b0;
        repeat (10) tick;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
